usb_tx_serializer: RTL and testbench
====================================

Name:
usb_tx_serializer

Overview:
- Parametrised USB transmit serializer: accepts packet bytes over a valid/ready stream, buffers them in a small FIFO, and drives d_plus_out/d_minus_out.
- Line encoding: SYNC, NRZI-encoded LSB-first data, bit stuffing, EOP.
- Used in the usb_top output path. Also serves as the reusable line driver for byte-stream stimulus, replacing per-cycle file reads.

Parameters:
- CLKS_PER_BIT, 8: clock cycles each line bit is held; must be ≥2.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥2.
- EOP_SE0_BITS, 2: bit times of SE0 in EOP.
- LOW_SPEED, 0: 0 = full-speed (J: d_plus=1, d_minus=0); 1 = low-speed (J: d_plus=0, d_minus=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  synchronous, active-high reset. The port keeps the codebase reset name; polarity is high.
- tx_data  in  8  packet byte.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_last  in  1  byte is the final byte of the packet.
- tx_ready  out  1  FIFO can accept a byte this cycle.
- d_plus_out  out  1  registered D+ line.
- d_minus_out  out  1  registered D- line.
- busy  out  1  high from SYNC start through the final EOP J bit.
- tx_done  out  1  one-cycle pulse at the end of a normal EOP.
- tx_err  out  1  one-cycle pulse on underrun abort.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (n_rst=1 at an edge), including mid-packet:
  - Outputs at the next edge: d lines = J, tx_ready=0, busy=0, tx_done=0, tx_err=0.
  - FIFO flushed, FSM to IDLE, bit and stuff counters cleared.
  - tx_ready goes to 1 on the first edge after n_rst deasserts.
- FIFO:
  - Write on tx_valid & tx_ready. Each entry stores {tx_last, tx_data}.
  - tx_ready = !full. A write while full is impossible by handshake.
  - Simultaneous read and write when full: the read frees the slot next cycle; tx_ready is not combinationally raised.
  - Pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
- FSM states: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
  - IDLE: line = J. If the FIFO is non-empty, go to SYNC. The first SYNC bit appears on the lines at the 2nd rising edge after the accepting edge.
  - SYNC: 8 bits, 0x80 LSB-first (seven 0s, then one 1). The ones-counter is 1 leaving SYNC.
  - DATA: pop a byte, shift out LSB-first.
    - After bit 7: if that entry's last flag is set, go to EOP_SE0; else pop the next byte.
    - If the next byte is needed and the FIFO is empty: underrun. Go to EOP_SE0, pulse tx_err at EOP_J exit, no tx_done.
  - STUFF: entered after 6 consecutive raw 1s. Emits one raw 0, then resumes the interrupted bit stream; the ones-counter resets.
    - A stuff bit owed after the last data bit is sent before EOP.
  - EOP_SE0: d_plus=d_minus=0 for EOP_SE0_BITS bit times.
  - EOP_J: J for 1 bit time, then go to IDLE. tx_done pulses on that transition.
  - busy drops on the same edge. A packet already queued may start SYNC on the next edge.
- NRZI: raw 0 toggles the line state J↔K; raw 1 holds it. The NRZI state is J at each SYNC start.
- Bit timer: counts 0..CLKS_PER_BIT-1. Line state changes only when the timer wraps. Every bit, including SE0 and J, lasts exactly CLKS_PER_BIT cycles.
- The ones-counter counts raw data bits only; it is 3 bits and saturates at 6.

Test Plan:
- Single packet: CLKS_PER_BIT=4, LOW_SPEED=0; send 0xA5 with tx_last.
  - Required line bit sequence: K J K J K J K K | K J J K J J K K | SE0 SE0 J.
  - 76 cycles from the first K; tx_done is a single pulse; busy is high for exactly 76 cycles.
- Bit stuffing: send 0xFF with tx_last.
  - A stuffed 0 follows the 5th data bit: 9 data bit times, line toggles once mid-byte.
  - Then send 0x3F,0x00: a stuff bit is inserted after bit 5 of 0x3F, 6 ones including the SYNC-carried 1.
- Backpressure: FIFO_DEPTH=4; drive tx_valid continuously with 6 bytes.
  - tx_ready drops after 4 accepts and re-asserts as bytes are popped.
  - All 6 bytes transmitted in order; no byte lost or duplicated.
- Underrun: send 0x12 without tx_last, then stop.
  - After 0x12, the sequence is SE0 SE0 J, then tx_err pulses once; tx_done stays 0.
- Reset mid-packet: assert n_rst during the 4th data bit.
  - Next edge: lines = J, busy=0, FIFO empty.
  - A new packet 0x01 afterwards transmits correctly from SYNC.
- LOW_SPEED=1: repeat the single-packet test; the d_plus/d_minus levels are inverted relative to full speed, and SE0 is unchanged.

Source files
------------

// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: byte FIFO feeding a line encoder that emits SYNC,
// NRZI-coded LSB-first data with bit stuffing, and an SE0/J end-of-packet.
// The FSM runs one cycle ahead of the registered line outputs. busy, tx_done
// and tx_err are registered alongside the lines, so they always stay aligned
// with what is on the wire.
module usb_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned EOP_SE0_BITS = 2,
    parameter bit          LOW_SPEED    = 1'b0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned EW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [EW-1:0] SE0_MAX   = EW'(EOP_SE0_BITS - 1);
    // D+ level for the J state; K is the complement, SE0 drives both low.
    localparam logic J_DP = ~LOW_SPEED;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StStuff,
        StEopSe0,
        StEopJ
    } state_e;

    // ------------------------------------------------------------------
    // Byte FIFO: entries are {last, data}; pointers carry an extra wrap bit.
    // ------------------------------------------------------------------
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          tx_ready_q;
    logic          fifo_wr;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full_d;
    logic [8:0]    fifo_head;

    assign fifo_wr    = tx_valid & tx_ready_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values and the fullness they imply.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, fifo_wr};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, fifo_pop};
        fifo_full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and ready registers; ready reflects post-update fullness.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_ready_q <= ~fifo_full_d;
        end
    end

    // Storage write; contents need no reset since the pointers are flushed.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {tx_last, tx_data};
        end
    end

    // ------------------------------------------------------------------
    // Line encoder
    // ------------------------------------------------------------------
    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    idx_q;      // bit index within SYNC or the current byte
    logic [EW-1:0] se0_cnt_q;
    logic [2:0]    ones_q;     // consecutive raw ones, saturating at 6
    logic          level_q;    // NRZI level of the current bit, 1 = J
    logic [7:0]    byte_q;
    logic          last_q;
    logic          abort_q;    // packet ended by underrun
    logic          dp_q, dm_q;
    logic          busy_q;
    logic          tx_done_q;
    logic          tx_err_q;

    logic          wrap;
    logic          stuff_due;
    logic          byte_end;
    logic          need_byte;
    logic [2:0]    idx_inc;
    logic          line_dp, line_dm;

    assign wrap      = (timer_q == TIMER_MAX);
    assign stuff_due = (state_q == StData) && (ones_q == 3'd6);
    assign idx_inc   = idx_q + 3'd1;
    // A fresh byte is owed after the last SYNC bit or after a non-final byte.
    assign byte_end  = (idx_q == 3'd7) &&
                       ((state_q == StSync) ||
                        (((state_q == StData) || (state_q == StStuff)) && !last_q));
    assign need_byte = wrap && !stuff_due && byte_end;
    assign fifo_pop  = need_byte && !fifo_empty;

    function automatic logic lvl_next(input logic lvl, input logic raw);
        return raw ? lvl : ~lvl;
    endfunction

    function automatic logic [2:0] ones_next(input logic [2:0] ones, input logic raw);
        if (!raw) begin
            return 3'd0;
        end
        return (ones == 3'd6) ? 3'd6 : ones + 3'd1;
    endfunction

    // Line symbol for the bit the FSM is currently timing.
    always_comb begin
        line_dp = J_DP;
        line_dm = ~J_DP;
        unique case (state_q)
            StSync, StData, StStuff: begin
                line_dp = level_q ? J_DP : ~J_DP;
                line_dm = level_q ? ~J_DP : J_DP;
            end
            StEopSe0: begin
                line_dp = 1'b0;
                line_dm = 1'b0;
            end
            default: ;
        endcase
    end

    // Encoder FSM: advances one line bit per timer wrap; outputs lag by a cycle.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            idx_q     <= '0;
            se0_cnt_q <= '0;
            ones_q    <= '0;
            level_q   <= 1'b1;
            byte_q    <= '0;
            last_q    <= 1'b0;
            abort_q   <= 1'b0;
            dp_q      <= J_DP;
            dm_q      <= ~J_DP;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            dp_q      <= line_dp;
            dm_q      <= line_dm;
            busy_q    <= (state_q != StIdle);
            // First idle cycle after a packet marks its completion.
            tx_done_q <= busy_q && (state_q == StIdle) && !abort_q;
            tx_err_q  <= busy_q && (state_q == StIdle) && abort_q;

            if (state_q == StIdle) begin
                timer_q <= '0;
                if (!fifo_empty) begin
                    // SYNC bit 0 is a raw 0, so the line leaves J for K.
                    state_q <= StSync;
                    idx_q   <= '0;
                    level_q <= 1'b0;
                    ones_q  <= '0;
                    abort_q <= 1'b0;
                end
            end else begin
                timer_q <= wrap ? '0 : timer_q + 1'b1;
                if (wrap) begin
                    unique case (state_q)
                        StSync, StData, StStuff: begin
                            if (stuff_due) begin
                                state_q <= StStuff;
                                level_q <= ~level_q;
                                ones_q  <= '0;
                            end else if (need_byte) begin
                                if (fifo_empty) begin
                                    state_q   <= StEopSe0;
                                    se0_cnt_q <= '0;
                                    abort_q   <= 1'b1;
                                end else begin
                                    state_q <= StData;
                                    idx_q   <= '0;
                                    byte_q  <= fifo_head[7:0];
                                    last_q  <= fifo_head[8];
                                    level_q <= lvl_next(level_q, fifo_head[0]);
                                    ones_q  <= ones_next(ones_q, fifo_head[0]);
                                end
                            end else if (idx_q == 3'd7) begin
                                // Final byte (and any owed stuff bit) is out.
                                state_q   <= StEopSe0;
                                se0_cnt_q <= '0;
                            end else if (state_q == StSync) begin
                                idx_q   <= idx_inc;
                                level_q <= lvl_next(level_q, idx_inc == 3'd7);
                                ones_q  <= ones_next(ones_q, idx_inc == 3'd7);
                            end else begin
                                state_q <= StData;
                                idx_q   <= idx_inc;
                                level_q <= lvl_next(level_q, byte_q[idx_inc]);
                                ones_q  <= ones_next(ones_q, byte_q[idx_inc]);
                            end
                        end
                        StEopSe0: begin
                            if (se0_cnt_q == SE0_MAX) begin
                                state_q <= StEopJ;
                            end else begin
                                se0_cnt_q <= se0_cnt_q + 1'b1;
                            end
                        end
                        StEopJ: begin
                            state_q <= StIdle;
                        end
                        default: begin
                            state_q <= StIdle;
                        end
                    endcase
                end
            end
        end
    end

    assign tx_ready    = tx_ready_q;
    assign d_plus_out  = dp_q;
    assign d_minus_out = dm_q;
    assign busy        = busy_q;
    assign tx_done     = tx_done_q;
    assign tx_err      = tx_err_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: a full-speed and a low-speed instance share the
// same byte stream; every line cycle is compared with a symbol list built from
// the line-coding rules (SYNC, NRZI, stuffing after six ones, SE0/J EOP).
module tb_usb_tx_serializer;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int SE0B  = 2;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;

    logic tx_ready, dp, dm, busy, tx_done, tx_err;
    logic ls_tx_ready, ls_dp, ls_dm, ls_busy, ls_tx_done, ls_tx_err;

    usb_tx_serializer #(
        .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .EOP_SE0_BITS(SE0B), .LOW_SPEED(1'b0)
    ) u_fs (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(tx_ready), .d_plus_out(dp), .d_minus_out(dm),
        .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    usb_tx_serializer #(
        .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .EOP_SE0_BITS(SE0B), .LOW_SPEED(1'b1)
    ) u_ls (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(ls_tx_ready), .d_plus_out(ls_dp),
        .d_minus_out(ls_dm), .busy(ls_busy), .tx_done(ls_tx_done), .tx_err(ls_tx_err)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] pkt_q[$];
    bit         pkt_last;
    int         sym_q[$];       // 0 = SE0, 1 = J, 2 = K
    int         first_acc_edge;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {d_plus, d_minus} for a symbol on a full- or low-speed line.
    function automatic logic [1:0] line_of(input int s, input bit ls);
        logic p;
        if (s == 0) return 2'b00;
        p = (s == 1) ^ ls;
        return {p, ~p};
    endfunction

    task automatic build_model();
        bit raw[$];
        bit lvl;
        int ones;
        sym_q.delete();
        for (int i = 0; i < 8; i++) raw.push_back(i == 7);
        foreach (pkt_q[k]) for (int b = 0; b < 8; b++) raw.push_back(pkt_q[k][b]);
        lvl  = 1'b1;
        ones = 0;
        foreach (raw[i]) begin
            if (raw[i]) ones++;
            else begin
                lvl  = ~lvl;
                ones = 0;
            end
            sym_q.push_back(lvl ? 1 : 2);
            if (ones == 6) begin
                lvl  = ~lvl;
                ones = 0;
                sym_q.push_back(lvl ? 1 : 2);
            end
        end
        for (int i = 0; i < SE0B; i++) sym_q.push_back(0);
        sym_q.push_back(1);
    endtask

    task automatic send_bytes();
        int  i = 0;
        int  guard = 0;
        bit  full_checked = 0;
        first_acc_edge = -1;
        while (i < pkt_q.size() && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (i == DEPTH && pkt_q.size() > DEPTH && !full_checked) begin
                check_eq("ready_low_when_full", tx_ready, 1'b0);
                full_checked = 1;
            end
            tx_valid = 1'b1;
            tx_data  = pkt_q[i];
            tx_last  = pkt_last && (i == pkt_q.size() - 1);
            if (tx_ready) begin
                if (i == 0) first_acc_edge = edges + 1;
                i++;
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        check_eq("bytes_accepted", i, pkt_q.size());
    endtask

    task automatic watch_packet(input bit exp_err);
        int w = 0;
        int len;
        int s;
        do begin
            @(negedge clk);
            w++;
        end while (busy !== 1'b1 && w < 300);
        if (busy !== 1'b1) begin
            check_eq("busy_rise", busy, 1'b1);
            return;
        end
        check_eq("sync_latency", edges - first_acc_edge, 2);
        len = sym_q.size() * C;
        for (int n = 0; n < len; n++) begin
            if (n > 0) @(negedge clk);
            s = sym_q[n / C];
            check_eq($sformatf("fs_line[%0d]", n), {dp, dm}, line_of(s, 1'b0));
            check_eq($sformatf("ls_line[%0d]", n), {ls_dp, ls_dm}, line_of(s, 1'b1));
            check_eq($sformatf("busy[%0d]", n), {busy, ls_busy}, 2'b11);
            check_eq($sformatf("no_pulse[%0d]", n), {tx_done, tx_err}, 2'b00);
        end
        @(negedge clk);
        check_eq("busy_fall", {busy, ls_busy}, 2'b00);
        check_eq("end_pulse_fs", {tx_done, tx_err}, {~exp_err, exp_err});
        check_eq("end_pulse_ls", {ls_tx_done, ls_tx_err}, {~exp_err, exp_err});
        check_eq("idle_line", {dp, dm, ls_dp, ls_dm}, 4'b1001);
        @(negedge clk);
        check_eq("pulse_single", {tx_done, tx_err}, 2'b00);
    endtask

    task automatic run_packet();
        build_model();
        fork
            send_bytes();
            watch_packet(!pkt_last);
        join
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int saw_busy;
        int w;
        repeat (3) @(negedge clk);
        check_eq("rst_lines", {dp, dm, ls_dp, ls_dm}, 4'b1001);
        check_eq("rst_busy", {busy, ls_busy}, 2'b00);
        check_eq("rst_ready", tx_ready, 1'b0);
        check_eq("rst_pulses", {tx_done, tx_err}, 2'b00);
        n_rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", tx_ready, 1'b1);

        // Single byte, then stuffing cases, backpressure and underrun.
        pkt_q = '{8'hA5};                         pkt_last = 1; run_packet();
        pkt_q = '{8'hFF};                         pkt_last = 1; run_packet();
        pkt_q = '{8'h3F, 8'h00};                  pkt_last = 1; run_packet();
        pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}; pkt_last = 1; run_packet();
        pkt_q = '{8'h12};                         pkt_last = 0; run_packet();

        // Reset during the 4th data bit with bytes still queued.
        pkt_q = '{8'hC3, 8'h5A, 8'h77};
        pkt_last = 1;
        fork
            send_bytes();
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (busy !== 1'b1 && w < 300);
                check_eq("rst_test_busy", busy, 1'b1);
                repeat (11 * C + 1) @(negedge clk);
            end
        join
        n_rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_lines", {dp, dm, ls_dp, ls_dm}, 4'b1001);
        check_eq("midrst_busy", {busy, ls_busy}, 2'b00);
        check_eq("midrst_ready", tx_ready, 1'b0);
        n_rst = 1'b0;
        saw_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) saw_busy++;
        end
        check_eq("fifo_flushed", saw_busy, 0);
        pkt_q = '{8'h01}; pkt_last = 1; run_packet();

        // Randomized packets, biased toward 0xFF to exercise stuffing.
        for (int p = 0; p < 14; p++) begin
            int len;
            len = $urandom_range(1, 6);
            pkt_q.delete();
            for (int k = 0; k < len; k++) begin
                pkt_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            pkt_last = ($urandom_range(0, 5) != 0);
            run_packet();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
